// File: rtl/alu_muldiv_seq_if.sv
// Request/result and shared-ALU signal bundle for alu_muldiv_seq.
// The slave modport is the sequencer; the master modport is the CPU side that also owns the ALU.
interface alu_muldiv_seq_if;
  // Handshakes: start is taken only on an edge where busy=0 and the sequencer is idle.
  // done pulses for one cycle, and res/err are valid from that edge. alu_req asks for
  // the ALU, and an ALU step commits only on an edge where alu_gnt=1.
  logic       start;
  logic       op_div;
  logic [7:0] a_hi;
  logic [7:0] a_lo;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [1:0] err;
  logic [7:0] res_hi;
  logic [7:0] res_lo;
  logic       alu_req;
  logic       alu_gnt;
  logic [8:0] alu_op;
  logic [7:0] alu_r;
  logic [7:0] alu_dr;
  logic       alu_c;
  logic [7:0] alu_out;
  logic       alu_cout;
  logic [2:0] dbg_state;

  modport slave (
    input  start, op_div, a_hi, a_lo, b, alu_gnt, alu_out, alu_cout,
    output busy, done, err, res_hi, res_lo, alu_req, alu_op, alu_r, alu_dr, alu_c,
           dbg_state
  );

  modport master (
    output start, op_div, a_hi, a_lo, b, alu_gnt, alu_out, alu_cout,
    input  busy, done, err, res_hi, res_lo, alu_req, alu_op, alu_r, alu_dr, alu_c,
           dbg_state
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// 8x8 multiply / 16:8 divide sequencer that borrows the core's 8-bit ALU one op per grant.
// Optional macro MULDIV_ABORT_EN adds an abort input that cancels a busy operation.
module alu_muldiv_seq #(
  parameter int ITER = 8
) (
  input  logic clk,
  input  logic RST_n,
`ifdef MULDIV_ABORT_EN
  input  logic abort,
`endif
  alu_muldiv_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_MADD, S_MRH, S_MRL, S_DCHK, S_DRL, S_DRH, S_DSUB
  } state_e;

  localparam logic [8:0] OP_ADD = 9'b0_0_000_01_00;
  localparam logic [8:0] OP_SUB = 9'b0_0_000_11_01;
  localparam logic [8:0] OP_ROR = 9'b1_1_000_00_11;
  localparam logic [8:0] OP_ROL = 9'b1_0_000_00_11;
  localparam logic [2:0] LAST   = 3'(ITER - 1);

  state_e     state_q, state_d;
  logic [7:0] h_q, h_d, l_q, l_d, b_q, b_d;
  logic       k_q, k_d, m_q, m_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d, done_q, done_d;
  logic [1:0] err_q, err_d;
  logic [7:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic       alu_req_q, alu_req_d, alu_c_q, alu_c_d;
  logic [8:0] alu_op_q, alu_op_d;
  logic [7:0] alu_r_q, alu_r_d, alu_dr_q, alu_dr_d;
  logic       finish;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    l_d      = l_q;
    b_d      = b_q;
    k_d      = k_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    finish   = 1'b0;

    if (state_q == S_IDLE) begin
      if (bus.start) begin
        h_d   = bus.op_div ? bus.a_hi : 8'h00;
        l_d   = bus.a_lo;
        b_d   = bus.b;
        k_d   = 1'b0;
        m_d   = 1'b0;
        cnt_d = 3'd0;
        err_d = 2'b00;
        if (bus.op_div && (bus.b == 8'h00)) begin
          err_d  = 2'b01;
          done_d = 1'b1;
        end else begin
          busy_d  = 1'b1;
          state_d = bus.op_div ? S_DCHK : S_MADD;
        end
      end
    end else if (bus.alu_gnt) begin
      case (state_q)
        S_MADD: begin h_d = bus.alu_out; k_d = bus.alu_cout; state_d = S_MRH; end
        S_MRH:  begin h_d = bus.alu_out; k_d = bus.alu_cout; state_d = S_MRL; end
        S_MRL: begin
          l_d   = bus.alu_out;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST) finish = 1'b1;
          else               state_d = S_MADD;
        end
        S_DCHK: begin
          // High byte already >= divisor: the quotient cannot fit in 8 bits.
          if (bus.alu_cout) begin
            err_d   = 2'b10;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRL;
          end
        end
        S_DRL: begin l_d = bus.alu_out; k_d = bus.alu_cout; state_d = S_DRH; end
        S_DRH: begin h_d = bus.alu_out; m_d = bus.alu_cout; state_d = S_DSUB; end
        S_DSUB: begin
          // m_q is bit 8 of the shifted partial remainder, so it always fits the subtract.
          if (m_q || bus.alu_cout) begin
            h_d    = bus.alu_out;
            l_d[0] = 1'b1;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == LAST) finish = 1'b1;
          else               state_d = S_DRL;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (finish) begin
      res_hi_d = h_d;
      res_lo_d = l_d;
      done_d   = 1'b1;
      busy_d   = 1'b0;
      state_d  = S_IDLE;
    end

`ifdef MULDIV_ABORT_EN
    if (abort && busy_q) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      err_d    = err_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
    end
`endif
  end

  // ALU drive is registered from the next state so it is valid for the whole state.
  always_comb begin
    alu_req_d = 1'b0;
    alu_op_d  = 9'd0;
    alu_r_d   = 8'h00;
    alu_dr_d  = 8'h00;
    alu_c_d   = 1'b0;
    case (state_d)
      S_MADD: begin alu_req_d = 1'b1; alu_op_d = OP_ADD; alu_r_d = h_d;
                    alu_dr_d = l_d[0] ? b_d : 8'h00; end
      S_MRH:  begin alu_req_d = 1'b1; alu_op_d = OP_ROR; alu_r_d = h_d; alu_c_d = k_d; end
      S_MRL:  begin alu_req_d = 1'b1; alu_op_d = OP_ROR; alu_r_d = l_d; alu_c_d = k_d; end
      S_DCHK: begin alu_req_d = 1'b1; alu_op_d = OP_SUB; alu_r_d = h_d; alu_dr_d = b_d; end
      S_DRL:  begin alu_req_d = 1'b1; alu_op_d = OP_ROL; alu_r_d = l_d; end
      S_DRH:  begin alu_req_d = 1'b1; alu_op_d = OP_ROL; alu_r_d = h_d; alu_c_d = k_d; end
      S_DSUB: begin alu_req_d = 1'b1; alu_op_d = OP_SUB; alu_r_d = h_d; alu_dr_d = b_d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      state_q   <= S_IDLE;
      h_q       <= 8'h00;
      l_q       <= 8'h00;
      b_q       <= 8'h00;
      k_q       <= 1'b0;
      m_q       <= 1'b0;
      cnt_q     <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
      res_hi_q  <= 8'h00;
      res_lo_q  <= 8'h00;
      alu_req_q <= 1'b0;
      alu_op_q  <= 9'd0;
      alu_r_q   <= 8'h00;
      alu_dr_q  <= 8'h00;
      alu_c_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      l_q       <= l_d;
      b_q       <= b_d;
      k_q       <= k_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      alu_req_q <= alu_req_d;
      alu_op_q  <= alu_op_d;
      alu_r_q   <= alu_r_d;
      alu_dr_q  <= alu_dr_d;
      alu_c_q   <= alu_c_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.res_lo    = res_lo_q;
  assign bus.alu_req   = alu_req_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_r     = alu_r_q;
  assign bus.alu_dr    = alu_dr_q;
  assign bus.alu_c     = alu_c_q;
  assign bus.dbg_state = state_q;

endmodule
